// File: rtl/task_answer_packer_if.sv
// Handshake bundle of the answer packer: task-side beat input and packed-word output.
// Valid/ready: a transfer happens on a rising clock edge where valid and ready are both 1;
// the source holds its payload stable while valid is 1 and ready is 0, and ready never
// depends on anything the source drives in the same cycle except through registered state.
interface task_answer_packer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int STREAMS   = 1
);
    logic                          i_valid;
    logic                          o_in_ready;
    logic [STREAMS*IN_WIDTH-1:0]   i_data;
    logic                          i_last;
    logic [OUT_WIDTH-1:0]          o_data;
    logic [OUT_WIDTH/8-1:0]        o_keep;
    logic                          o_valid;
    logic                          i_ready;
    logic                          o_last;

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_in_ready, o_data, o_keep, o_valid, o_last
    );

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_in_ready, o_data, o_keep, o_valid, o_last
    );
endinterface

// File: rtl/task_answer_packer.sv
// Answer path behind a task core: serializes multi-stream beats, packs them LSB-first into
// OUT_WIDTH words, buffers them in a FWFT FIFO and reports answer size and task latency.
module task_answer_packer #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int STREAMS    = 1,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_task_start,
    task_answer_packer_if.slave    io_bus,
    output logic [CNT_WIDTH-1:0]   o_size_bytes,
    output logic [CNT_WIDTH-1:0]   o_lat,
    output logic                   o_lat_valid,
    output logic                   o_dbg_state
);

    localparam int RATIO    = OUT_WIDTH / IN_WIDTH;
    localparam int IN_BYTES = IN_WIDTH / 8;
    localparam int KEEP_W   = OUT_WIDTH / 8;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int SW       = (STREAMS > 1) ? $clog2(STREAMS) : 1;
    localparam int ENTRY_W  = OUT_WIDTH + KEEP_W + 1;

    localparam logic [AW:0]        C_DEPTH      = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]        C_STREAMS    = (AW+1)'(STREAMS);
    localparam logic [LW-1:0]      C_LANE_MAX   = LW'(RATIO - 1);
    localparam logic [SW-1:0]      C_SIDX_MAX   = SW'(STREAMS - 1);
    localparam logic [CNT_WIDTH:0] C_BEAT_BYTES = (CNT_WIDTH+1)'(STREAMS * IN_BYTES);

    typedef enum logic {S_IDLE, S_SER} state_t;

    state_t                       r_state;
    state_t                       w_state_nx;
    logic [SW-1:0]                r_sidx;
    logic [SW-1:0]                w_sidx_nx;
    logic [STREAMS*IN_WIDTH-1:0]  r_beat_data;
    logic                         r_beat_last;

    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_emit;
    logic [IN_WIDTH-1:0]          w_emit_word;
    logic                         w_emit_last;

    logic [LW-1:0]                r_lane;
    logic [OUT_WIDTH-1:0]         r_pack_data;
    logic [KEEP_W-1:0]            r_pack_keep;
    logic [OUT_WIDTH-1:0]         w_word_data;
    logic [KEEP_W-1:0]            w_word_keep;
    logic                         w_push;

    logic [ENTRY_W-1:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]                r_wr_ptr;
    logic [AW-1:0]                r_rd_ptr;
    logic [AW:0]                  r_count;
    logic [AW:0]                  w_free;
    logic                         w_fifo_valid;
    logic                         w_pop;
    logic [ENTRY_W-1:0]           w_head;

    logic [CNT_WIDTH-1:0]         r_size;
    logic [CNT_WIDTH:0]           w_size_sum;
    logic [CNT_WIDTH-1:0]         r_lat_cnt;
    logic                         r_lat_run;
    logic [CNT_WIDTH-1:0]         r_lat;
    logic                         r_lat_valid;

    assign w_free       = C_DEPTH - r_count;
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && io_bus.i_ready;
    assign w_head       = r_mem[r_rd_ptr];

    // Stream 0 leaves in the accept cycle; the register keeps only the streams still to go.
    always_comb begin
        w_state_nx  = r_state;
        w_sidx_nx   = r_sidx;
        w_emit      = 1'b0;
        w_emit_word = '0;
        w_emit_last = 1'b0;
        w_in_ready  = i_rst_n && (r_state == S_IDLE) && (w_free >= C_STREAMS);
        w_accept    = io_bus.i_valid && w_in_ready && !i_clear;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_emit      = 1'b1;
                    w_emit_word = io_bus.i_data[IN_WIDTH-1:0];
                    w_emit_last = (STREAMS == 1) && io_bus.i_last;
                    if (STREAMS > 1) begin
                        w_state_nx = S_SER;
                        w_sidx_nx  = SW'(1);
                    end
                end
            end
            S_SER: begin
                w_emit      = 1'b1;
                w_emit_word = r_beat_data[IN_WIDTH-1:0];
                w_emit_last = (r_sidx == C_SIDX_MAX) && r_beat_last;
                if (r_sidx == C_SIDX_MAX) begin
                    w_state_nx = S_IDLE;
                    w_sidx_nx  = '0;
                end else begin
                    w_sidx_nx = r_sidx + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (i_clear) begin
            w_emit     = 1'b0;
            w_state_nx = S_IDLE;
            w_sidx_nx  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sidx      <= '0;
            r_beat_data <= '0;
            r_beat_last <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sidx  <= w_sidx_nx;
            if (w_accept) begin
                r_beat_data <= io_bus.i_data >> IN_WIDTH;
                r_beat_last <= io_bus.i_last;
            end else if (r_state == S_SER) begin
                r_beat_data <= r_beat_data >> IN_WIDTH;
            end
        end
    end

    always_comb begin
        w_word_data = r_pack_data;
        w_word_keep = r_pack_keep;
        w_word_data[r_lane*IN_WIDTH +: IN_WIDTH] = w_emit_word;
        w_word_keep[r_lane*IN_BYTES +: IN_BYTES] = '1;
        w_push = w_emit && ((r_lane == C_LANE_MAX) || w_emit_last);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_lane      <= '0;
            r_pack_data <= '0;
            r_pack_keep <= '0;
        end else if (w_push) begin
            r_lane      <= '0;
            r_pack_data <= '0;
            r_pack_keep <= '0;
        end else if (w_emit) begin
            r_lane      <= r_lane + 1'b1;
            r_pack_data <= w_word_data;
            r_pack_keep <= w_word_keep;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_emit_last, w_word_keep, w_word_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_size_sum = {1'b0, r_size} + C_BEAT_BYTES;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_size <= '0;
        end else if (w_accept) begin
            r_size <= w_size_sum[CNT_WIDTH] ? '1 : w_size_sum[CNT_WIDTH-1:0];
        end
    end

    // o_lat counts clock edges from the start cycle to the accept cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_lat_cnt   <= '0;
            r_lat_run   <= 1'b0;
            r_lat       <= '0;
            r_lat_valid <= 1'b0;
        end else if (i_task_start) begin
            r_lat <= '0;
            if (w_accept) begin
                r_lat_run   <= 1'b0;
                r_lat_valid <= 1'b1;
            end else begin
                r_lat_cnt   <= CNT_WIDTH'(1);
                r_lat_run   <= 1'b1;
                r_lat_valid <= 1'b0;
            end
        end else if (r_lat_run) begin
            if (w_accept) begin
                r_lat       <= r_lat_cnt;
                r_lat_valid <= 1'b1;
                r_lat_run   <= 1'b0;
            end else if (!(&r_lat_cnt)) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
        end
    end

    assign io_bus.o_in_ready = w_in_ready;
    assign io_bus.o_valid    = w_fifo_valid;
    assign io_bus.o_data     = w_fifo_valid ? w_head[OUT_WIDTH-1:0] : '0;
    assign io_bus.o_keep     = w_fifo_valid ? w_head[OUT_WIDTH +: KEEP_W] : '0;
    assign io_bus.o_last     = w_fifo_valid && w_head[ENTRY_W-1];
    assign o_size_bytes      = r_size;
    assign o_lat             = r_lat;
    assign o_lat_valid       = r_lat_valid;
    assign o_dbg_state       = (r_state == S_SER);

endmodule

// File: tb/tb_task_answer_packer.sv
// Bench for task_answer_packer: a single-stream instance (depth 8) and a two-stream instance
// (depth 4) driven with directed vectors; output words are checked against expected queues.
module tb_task_answer_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_n_a, clear_a, start_a, rst_n_b, clear_b, start_b;
    logic [31:0] size_a, lat_a, size_b, lat_b;
    logic latv_a, latv_b, dbg_a, dbg_b;
    bit   done_a;

    task_answer_packer_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .STREAMS(1)) bus_a ();
    task_answer_packer_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .STREAMS(2)) bus_b ();

    task_answer_packer #(
        .IN_WIDTH(16), .OUT_WIDTH(32), .STREAMS(1), .FIFO_DEPTH(8), .CNT_WIDTH(32)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .i_clear(clear_a), .i_task_start(start_a),
        .io_bus(bus_a), .o_size_bytes(size_a), .o_lat(lat_a), .o_lat_valid(latv_a),
        .o_dbg_state(dbg_a)
    );

    task_answer_packer #(
        .IN_WIDTH(16), .OUT_WIDTH(32), .STREAMS(2), .FIFO_DEPTH(4), .CNT_WIDTH(32)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_clear(clear_b), .i_task_start(start_b),
        .io_bus(bus_b), .o_size_bytes(size_b), .o_lat(lat_b), .o_lat_valid(latv_b),
        .o_dbg_state(dbg_b)
    );

    // Expected word format: {last, keep[3:0], data[31:0]}
    logic [36:0] exp_a_q[$];
    logic [36:0] exp_b_q[$];

    function automatic logic [36:0] mk(input logic l, input logic [3:0] k, input logic [31:0] d);
        return {l, k, d};
    endfunction

    function automatic logic [15:0] dat(input int k);
        return {8'(k), 8'(8'hFF - 8'(k))};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- output monitors / scoreboards ----------------
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [36:0] held_a, held_b;

    always @(negedge clk) begin
        logic [36:0] got;
        got = {bus_a.o_last, bus_a.o_keep, bus_a.o_data};
        if (rst_n_a && stall_a) chk("hold_a", {bus_a.o_valid, got}, {1'b1, held_a});
        if (rst_n_a && bus_a.o_valid && bus_a.i_ready) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word_a actual=0x%0h required=none", got);
            end else begin
                chk("word_a", got, exp_a_q.pop_front());
            end
        end
        stall_a = rst_n_a && bus_a.o_valid && !bus_a.i_ready;
        held_a  = got;
    end

    always @(negedge clk) begin
        logic [36:0] got;
        got = {bus_b.o_last, bus_b.o_keep, bus_b.o_data};
        if (rst_n_b && stall_b) chk("hold_b", {bus_b.o_valid, got}, {1'b1, held_b});
        if (rst_n_b && bus_b.o_valid && bus_b.i_ready) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word_b actual=0x%0h required=none", got);
            end else begin
                chk("word_b", got, exp_b_q.pop_front());
            end
        end
        stall_b = rst_n_b && bus_b.o_valid && !bus_b.i_ready;
        held_b  = got;
    end

    // ---------------- drivers ----------------
    task automatic send_a(input logic [15:0] d, input logic l, input int budget, output bit ok);
        int n;
        n = 0;
        bus_a.i_data  = d;
        bus_a.i_last  = l;
        bus_a.i_valid = 1'b1;
        @(negedge clk);
        while (!bus_a.o_in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus_a.o_in_ready;
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus_a.i_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l, input int budget, output bit ok);
        int n;
        n = 0;
        bus_b.i_data  = d;
        bus_b.i_last  = l;
        bus_b.i_valid = 1'b1;
        @(negedge clk);
        while (!bus_b.o_in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus_b.o_in_ready;
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus_b.i_valid = 1'b0;
    endtask

    task automatic put_a(input logic [15:0] d, input logic l);
        bit ok;
        send_a(d, l, 200, ok);
        chk("accept_a", ok, 1);
    endtask

    task automatic put_b(input logic [31:0] d, input logic l);
        bit ok;
        send_b(d, l, 200, ok);
        chk("accept_b", ok, 1);
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (exp_a_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_a", exp_a_q.size(), 0);
        cyc(1);
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while (exp_b_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_b", exp_b_q.size(), 0);
        cyc(1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] din;
        logic        dlast;
        bit          exp_push;
        logic [36:0] exp_word;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        vecs[0] = '{16'h1111, 1'b0, 1'b0, 37'h0};
        vecs[1] = '{16'h2222, 1'b0, 1'b1, mk(1'b0, 4'hF, 32'h2222_1111)};
        vecs[2] = '{16'h3333, 1'b1, 1'b1, mk(1'b1, 4'h3, 32'h0000_3333)};
        vecs[3] = '{16'hAAAA, 1'b1, 1'b1, mk(1'b1, 4'h3, 32'h0000_AAAA)};
        vecs[4] = '{16'h1234, 1'b0, 1'b0, 37'h0};
        vecs[5] = '{16'h5678, 1'b1, 1'b1, mk(1'b1, 4'hF, 32'h5678_1234)};
        vecs[6] = '{16'hFFFF, 1'b0, 1'b0, 37'h0};
        vecs[7] = '{16'h0001, 1'b0, 1'b1, mk(1'b0, 4'hF, 32'h0001_FFFF)};
        vecs[8] = '{16'hBEEF, 1'b1, 1'b1, mk(1'b1, 4'h3, 32'h0000_BEEF)};

        // ---------------- clock/reset ----------------
        rst_n_a = 1'b0; clear_a = 1'b0; start_a = 1'b0;
        rst_n_b = 1'b0; clear_b = 1'b0; start_b = 1'b0;
        bus_a.i_valid = 1'b0; bus_a.i_data = '0; bus_a.i_last = 1'b0; bus_a.i_ready = 1'b1;
        bus_b.i_valid = 1'b0; bus_b.i_data = '0; bus_b.i_last = 1'b0; bus_b.i_ready = 1'b1;
        cyc(3);
        chk("rst_valid_a", bus_a.o_valid, 0);
        chk("rst_in_ready_a", bus_a.o_in_ready, 0);
        chk("rst_data_a", {bus_a.o_last, bus_a.o_keep, bus_a.o_data}, 0);
        chk("rst_size_a", size_a, 0);
        chk("rst_lat_a", {latv_a, lat_a}, 0);
        chk("rst_valid_b", bus_b.o_valid, 0);
        chk("rst_size_b", size_b, 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        cyc(1);
        chk("idle_ready_a", bus_a.o_in_ready, 1);
        chk("idle_ready_b", bus_b.o_in_ready, 1);
        chk("idle_state_b", dbg_b, 0);

        // ---------------- single stream table ----------------
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].exp_push) exp_a_q.push_back(vecs[i].exp_word);
            put_a(vecs[i].din, vecs[i].dlast);
            chk("size_a", size_a, 2 * (i + 1));
        end
        drain_a();

        // ---------------- latency ----------------
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        chk("lat_busy_a", latv_a, 0);
        cyc(6);
        exp_a_q.push_back(mk(1'b1, 4'h3, 32'h0000_0A0A));
        put_a(16'h0A0A, 1'b1);
        chk("lat7_a", {latv_a, lat_a}, {1'b1, 32'd7});
        cyc(3);
        exp_a_q.push_back(mk(1'b1, 4'h3, 32'h0000_0B0B));
        put_a(16'h0B0B, 1'b1);
        chk("lat_hold_a", {latv_a, lat_a}, {1'b1, 32'd7});
        start_a = 1'b1;
        exp_a_q.push_back(mk(1'b1, 4'h3, 32'h0000_0C0C));
        put_a(16'h0C0C, 1'b1);
        start_a = 1'b0;
        chk("lat0_a", {latv_a, lat_a}, {1'b1, 32'd0});
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        chk("lat_restart_a", latv_a, 0);
        drain_a();

        // ---------------- clear drops partial word and simultaneous beat ----------------
        put_a(16'h5555, 1'b0);
        clear_a = 1'b1;
        put_a(16'h6666, 1'b0);
        clear_a = 1'b0;
        chk("clear_size_a", size_a, 0);
        chk("clear_lat_a", {latv_a, lat_a}, 0);
        exp_a_q.push_back(mk(1'b1, 4'h3, 32'h0000_7777));
        put_a(16'h7777, 1'b1);
        chk("after_clear_size_a", size_a, 2);
        drain_a();

        // ---------------- reset mid-answer with FIFO fill 3 ----------------
        bus_a.i_ready = 1'b0;
        for (int i = 1; i <= 7; i++) put_a(16'(i * 16'h0101), 1'b0);
        cyc(1);
        chk("fill_valid_a", bus_a.o_valid, 1);
        chk("fill_head_a", {bus_a.o_last, bus_a.o_keep, bus_a.o_data}, mk(1'b0, 4'hF, 32'h0202_0101));
        rst_n_a = 1'b0;
        cyc(1);
        rst_n_a = 1'b1;
        chk("reset_valid_a", bus_a.o_valid, 0);
        chk("reset_size_a", size_a, 0);
        bus_a.i_ready = 1'b1;
        exp_a_q.push_back(mk(1'b1, 4'h3, 32'h0000_7878));
        put_a(16'h7878, 1'b1);
        drain_a();

        // ---------------- 40 words with i_ready toggling ----------------
        done_a = 1'b0;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    if (k % 2 == 1)
                        exp_a_q.push_back(mk((k % 10) == 9, 4'hF, {dat(k), dat(k - 1)}));
                    put_a(dat(k), (k % 10) == 9);
                end
                done_a = 1'b1;
            end
            begin
                while (!done_a) begin
                    @(posedge clk);
                    #1;
                    bus_a.i_ready = ~bus_a.i_ready;
                end
            end
        join
        bus_a.i_ready = 1'b1;
        chk("wrap_size_a", size_a, 162);
        drain_a();

        // ---------------- two streams: serialization ----------------
        exp_b_q.push_back(mk(1'b1, 4'hF, 32'hBBBB_AAAA));
        put_b({16'hBBBB, 16'hAAAA}, 1'b1);
        chk("ser_ready_b", bus_b.o_in_ready, 0);
        chk("ser_state_b", dbg_b, 1);
        cyc(1);
        chk("ser_back_ready_b", bus_b.o_in_ready, 1);
        chk("size_b", size_b, 4);
        exp_b_q.push_back(mk(1'b0, 4'hF, 32'h2222_1111));
        put_b({16'h2222, 16'h1111}, 1'b0);
        drain_b();
        chk("size2_b", size_b, 8);

        // ---------------- two streams: back-pressure on depth 4 ----------------
        bus_b.i_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_b_q.push_back(mk(i == 3, 4'hF, {8'hB0, 8'(i), 8'hA0, 8'(i)}));
            put_b({8'hB0, 8'(i), 8'hA0, 8'(i)}, i == 3);
        end
        cyc(2);
        chk("full_ready_b", bus_b.o_in_ready, 0);
        chk("full_valid_b", bus_b.o_valid, 1);
        send_b(32'hB004_A004, 1'b1, 6, ok);
        chk("stall_accept_b", ok, 0);
        exp_b_q.push_back(mk(1'b1, 4'hF, 32'hB004_A004));
        bus_b.i_ready = 1'b1;
        put_b(32'hB004_A004, 1'b1);
        drain_b();
        chk("final_size_b", size_b, 24);

        chk("left_a", exp_a_q.size(), 0);
        chk("left_b", exp_b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
